fetch_mem_arbiter: RTL and testbench

- Shares the core's single memory bus between instruction fetch (address from the PC register) and load/store data accesses.
- Sequences each access with a request/ack bus handshake.
- Returns one-cycle iready/dready pulses; iready is the PC register's advance enable.
- Guards against bus hangs with a timeout and flags misaligned fetches.

---
 rtl/arb_pkg.sv | 19 +
 rtl/bus_timeout_ctr.sv | 36 +++
 rtl/fetch_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory-bus arbiter.
// Grant and state encodings plus the reset instruction.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    G_FETCH,
    G_DATA
  } grant_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts bus cycles spent waiting for ack.
// expired_o fires on the cycle the count would reach LIMIT.
module bus_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [8:0] LIM = 9'(LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (({1'b0, cnt_q} + 9'd1) == LIM);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one request/ack memory bus between fetch and load/store.
// Alternates grants under contention; aborts hung accesses.
module fetch_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        fetch_req,
  input  logic [31:0] pc_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        iready,
  output logic [31:0] instr_out,
  output logic        dready,
  output logic [31:0] d_rdata,
  output logic        ifault,
  output logic        dfault
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        irdy_q, irdy_d;
  logic        drdy_q, drdy_d;
  logic        ifl_q, ifl_d;
  logic        dfl_q, dfl_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] drd_q, drd_d;

  logic data_pend;
  logic grant_data;
  logic misalign;
  logic expired;

  assign data_pend  = d_read | d_write;
  assign grant_data = data_pend && (!fetch_req || last_q == G_FETCH);
  assign misalign   = pc_addr[1:0] != 2'b00;

  bus_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .clk_i    (clk),
    .rst_ni   (nRST),
    .clr_i    (!req_q || bus_ack),
    .en_i     (req_q && !bus_ack),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DATA;
        end else if (fetch_req) begin
          state_d = misalign ? RESP : FETCH;
        end
      end
      FETCH, DATA: begin
        if (bus_ack || expired) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    req_d   = req_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    ifl_d   = 1'b0;
    dfl_d   = 1'b0;
    instr_d = instr_q;
    drd_d   = drd_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          last_d  = G_DATA;
          req_d   = 1'b1;
          we_d    = d_write;
          adr_d   = d_addr;
          wdata_d = d_wdata;
          sel_d   = d_write ? d_sel : 4'hF;
        end else if (fetch_req) begin
          last_d = G_FETCH;
          if (misalign) begin
            ifl_d   = 1'b1;
            instr_d = RESET_INSTR;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = pc_addr;
            wdata_d = '0;
            sel_d   = 4'hF;
          end
        end
      end
      FETCH: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          irdy_d  = 1'b1;
          instr_d = bus_rdata;
        end else if (expired) begin
          req_d   = 1'b0;
          ifl_d   = 1'b1;
          instr_d = RESET_INSTR;
        end
      end
      DATA: begin
        if (bus_ack) begin
          req_d  = 1'b0;
          drdy_d = 1'b1;
          if (!we_q) drd_d = bus_rdata;
        end else if (expired) begin
          req_d = 1'b0;
          dfl_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      last_q  <= G_FETCH;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      ifl_q   <= 1'b0;
      dfl_q   <= 1'b0;
      instr_q <= RESET_INSTR;
      drd_q   <= '0;
    end else begin
      last_q  <= last_d;
      req_q   <= req_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
      ifl_q   <= ifl_d;
      dfl_q   <= dfl_d;
      instr_q <= instr_d;
      drd_q   <= drd_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_adr   = adr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;
  assign iready    = irdy_q;
  assign dready    = drdy_q;
  assign ifault    = ifl_q;
  assign dfault    = dfl_q;
  assign instr_out = instr_q;
  assign d_rdata   = drd_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Random fetch/load/store traffic against a transaction-level model.
// Expected responses are queued at grant and matched by a monitor.
module tb_fetch_mem_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic        bus_req, bus_we;
  logic [31:0] bus_adr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        iready, dready, ifault, dfault;
  logic [31:0] instr_out, d_rdata;

  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        t_ack = 1'b0;
  logic [31:0] t_rdata = '0;
  bit          run = 1'b0;

  assign bus_ack   = run ? m_ack : t_ack;
  assign bus_rdata = run ? m_rdata : t_rdata;

  fetch_mem_arbiter #(
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .fetch_req(fetch_req),
    .pc_addr  (pc_addr),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_sel    (d_sel),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_adr  (bus_adr),
    .bus_wdata(bus_wdata),
    .bus_sel  (bus_sel),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .iready   (iready),
    .instr_out(instr_out),
    .dready   (dready),
    .d_rdata  (d_rdata),
    .ifault   (ifault),
    .dfault   (dfault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind bits: {iready, dready, ifault, dfault}
  typedef struct {
    int          cyc;
    logic [3:0]  kind;
    logic [31:0] val;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } busrec_t;

  resp_t   exp_q[$];
  busrec_t cur;

  int          cyc = 0;
  int          free_at = 0;
  int          w_lo = 1;
  int          w_hi = 0;
  int          ack_at = -1;
  bit          last_data = 1'b0;
  logic [31:0] ack_val = '0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_drd = '0;

  // Transaction-level model: decides grants, ack timing and responses
  always @(posedge clk) begin
    int  n, k, rc;
    bit  gd, spur;
    if (run) begin
      cyc++;
      n = cyc - 1;
      if (n >= free_at && (fetch_req || d_read || d_write)) begin
        gd = (d_read || d_write) && (!fetch_req || !last_data);
        last_data = gd;
        if (!gd && pc_addr[1:0] != 2'b00) begin
          m_instr = NOP;
          exp_q.push_back('{n + 1, 4'b0010, NOP});
          free_at = n + 2;
        end else begin
          k = $urandom_range(1, 6);
          cur.adr   = gd ? d_addr : pc_addr;
          cur.we    = gd && d_write;
          cur.wdata = d_wdata;
          cur.sel   = cur.we ? d_sel : 4'hF;
          ack_val   = $urandom;
          w_lo      = n + 1;
          if (k <= TO) begin
            w_hi   = n + k;
            ack_at = n + k;
            rc     = n + k + 1;
          end else begin
            w_hi   = n + TO;
            ack_at = -1;
            rc     = n + TO + 1;
          end
          free_at = rc + 1;
          if (!gd) begin
            m_instr = (k <= TO) ? ack_val : NOP;
            exp_q.push_back('{rc, (k <= TO) ? 4'b1000 : 4'b0010, m_instr});
          end else begin
            if (k <= TO && !cur.we) m_drd = ack_val;
            exp_q.push_back('{rc, (k <= TO) ? 4'b0100 : 4'b0001, m_drd});
          end
        end
      end
      #1;
      spur    = ($urandom_range(0, 3) == 0);
      m_ack   = (cyc == ack_at) || (spur && !(cyc >= w_lo && cyc <= w_hi));
      m_rdata = (cyc == ack_at) ? ack_val : $urandom;
    end
  end

  logic [3:0] mp;
  resp_t      mr;
  bit         in_w;

  always @(negedge clk) begin
    if (run) begin
      in_w = (cyc >= w_lo) && (cyc <= w_hi);
      chk("bus_req", 32'(bus_req), 32'(in_w));
      if (in_w) begin
        chk("bus_adr", bus_adr, cur.adr);
        chk("bus_we", 32'(bus_we), 32'(cur.we));
        chk("bus_sel", 32'(bus_sel), 32'(cur.sel));
        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
      end
      mp = {iready, dready, ifault, dfault};
      if (mp != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(mp), 32'd0);
        end else begin
          mr = exp_q.pop_front();
          chk("pulse_kind", 32'(mp), 32'(mr.kind));
          chk("pulse_cycle", 32'(cyc), 32'(mr.cyc));
          if (mr.kind[3] || mr.kind[1]) chk("instr_out", instr_out, mr.val);
          else chk("d_rdata", d_rdata, mr.val);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mr = exp_q.pop_front();
        chk("missing_pulse", 32'(mp), 32'(mr.kind));
      end
    end
  end

  bit stop = 1'b0;

  task automatic fetch_agent();
    int n;
    while (!stop) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      pc_addr = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 5) == 0) pc_addr[1:0] = 2'($urandom_range(1, 3));
      fetch_req = 1'b1;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!(iready || ifault) && n < 40);
      chk("fetch_served", 32'(iready || ifault), 32'd1);
      fetch_req = 1'b0;
    end
  endtask

  task automatic data_agent();
    int n, r;
    while (!stop) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      r       = $urandom_range(0, 5);
      d_addr  = $urandom & 32'h0000_0FFC;
      d_wdata = $urandom;
      d_sel   = 4'($urandom);
      d_read  = (r <= 2) || (r == 5);
      d_write = (r >= 3);
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!(dready || dfault) && n < 40);
      chk("data_served", 32'(dready || dfault), 32'd1);
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  initial begin
    int n;
    #12;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_adr", bus_adr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_pulses", 32'({iready, dready, ifault, dfault}), 32'd0);
    chk("rst_instr_out", instr_out, NOP);
    chk("rst_d_rdata", d_rdata, 32'd0);

    @(negedge clk);
    nRST = 1'b1;
    run  = 1'b1;
    fork
      fetch_agent();
      data_agent();
      begin
        repeat (1500) @(posedge clk);
        stop = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    run = 1'b0;

    // Reset in the middle of a load, then a late ack after release
    t_ack   = 1'b0;
    d_read  = 1'b1;
    d_addr  = 32'h0000_0300;
    n = 0;
    while (!bus_req && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_req_high", 32'(bus_req), 32'd1);
    chk("midrst_adr", bus_adr, 32'h0000_0300);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_bus_adr", bus_adr, 32'd0);
    chk("midrst_bus_sel", 32'(bus_sel), 32'd0);
    chk("midrst_dready", 32'(dready), 32'd0);
    chk("midrst_instr", instr_out, NOP);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    d_read = 1'b0;
    @(negedge clk);
    nRST    = 1'b1;
    t_ack   = 1'b1;
    t_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("late_ack_req", 32'(bus_req), 32'd0);
      chk("late_ack_dready", 32'(dready), 32'd0);
      chk("late_ack_d_rdata", d_rdata, 32'd0);
    end
    t_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
